fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decode/control unit. Holds the PC and issues requests to instruction memory over a req/ready handshake. Presents a registered instruction, its PC and PC+4 to decode. Honours a decode stall via a one-entry skid buffer, and honours branch/jump redirects driven by pc_src/pc_target.

Parameters:
WIDTH, 32, instruction/address width
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP, 32'h0000_0013, instruction driven when output is invalid (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_src  input  1  redirect request: next fetch is pc_target
pc_target  input  WIDTH  redirect address, sampled when pc_src=1
stall  input  1  decode cannot accept; hold outputs
imem_req  output  1  fetch request to instruction memory
imem_addr  output  WIDTH  fetch address, stable while imem_req=1 and imem_ready=0
imem_ready  input  1  memory response this cycle; imem_rdata valid
imem_rdata  input  WIDTH  fetched instruction
ins  output  WIDTH  registered instruction to decode
pc_o  output  WIDTH  PC of ins
pc_plus4_o  output  WIDTH  pc_o + 4
ins_valid  output  1  ins/pc_o are a real fetched instruction

Behaviour:
- Reset (async, rst_n=0): fetch PC=RESET_PC, imem_req=0, ins=NOP, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4, ins_valid=0, skid empty, drop flag clear, state RUN.
- imem_addr is the fetch PC register, combinationally. All other outputs are registered.
- Handshake: once imem_req=1 it stays high with a constant imem_addr until the cycle imem_ready=1, the accept cycle. No request is ever abandoned. imem_ready while imem_req=0 is ignored.
- imem_req=1 in RUN when the skid is empty. In SKID, imem_req=0. An outstanding request is always completed first.
- Accept with no stall and no drop: ins<=imem_rdata, pc_o<=fetch PC, ins_valid<=1, fetch PC<=fetch PC+4. A new request follows on the next cycle, giving 1 instr/cycle when memory returns ready every cycle.
- Accept with stall=1 and ins_valid=1: data/PC go to the skid, state SKID, outputs hold, fetch PC advances.
- stall=1 always holds ins/pc_o/ins_valid unchanged unless redirect.
- SKID with stall=0: the skid moves to the outputs next edge, the skid empties, state RUN, and the request resumes that same cycle.
- No accept and stall=0: ins_valid<=0, ins<=NOP.
- Redirect (pc_src=1) has priority over stall and skid:
  - ins_valid<=0, ins<=NOP, skid cleared, state RUN, fetch target=pc_target.
  - No request outstanding, or accept in the same cycle: the accepted data is discarded and fetch PC<=pc_target next edge.
  - Request outstanding, not accepted: set drop flag, hold the old address until accept, discard that response, then fetch PC<=pc_target.
  - A second redirect while drop is set overwrites the stored target.
- PC arithmetic modulo 2^WIDTH; fetch PC+4 wraps 32'hFFFF_FFFC -> 0. pc_target[1:0] is forced to 0.
- Reset mid-request: all state clears immediately, and imem_req drops asynchronously.

Test Plan:
- Reset release, imem_ready=1 every cycle -> addresses 0,4,8,C on consecutive cycles. ins_valid first high 1 cycle after the first accept, pc_o 0,4,8.
- imem_ready delayed 3 cycles on addr 4 -> imem_addr holds 4 for 4 cycles, then ins_valid=0 for the 3 wait cycles, then ins=rdata, pc_o=4.
- stall=1 for 3 cycles with ready=1 -> one response captured in the skid, imem_req=0 while the skid is full, outputs frozen. After stall drops, the skid instruction appears next, with no loss or duplication.
- pc_src=1, pc_target=0x100 with no outstanding request -> next imem_addr=0x100, ins_valid=0 for one cycle, then pc_o=0x100.
- pc_src=1, target 0x200 while addr 0x8 is outstanding (ready 2 cycles later) -> addr 0x8 held until accepted, its data never reaches ins, next request 0x200. A redirect during stall clears the skid.
- Start PC 0xFFFF_FFFC -> next address 0x0. Assert rst_n=0 mid-wait -> imem_req=0 and ins_valid=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that sits directly in front of decode.
//
// It holds the fetch PC and issues requests to instruction memory over a req/ready
// handshake. Each fetched instruction is presented to decode as a registered
// instruction together with its PC and PC+4. A decode stall is absorbed by a
// one-entry skid buffer. A branch/jump redirect (pc_src/pc_target) flushes
// everything in flight.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   pc_src        redirect request; the next fetch comes from pc_target
//   pc_target     redirect address; bits [1:0] are ignored (forced to 0)
//   stall         decode cannot accept; the outputs hold
//   imem_req      fetch request; held high with a stable imem_addr until accepted
//   imem_addr     fetch address (the fetch PC register, combinational)
//   imem_ready    memory response this cycle; imem_rdata is valid
//   imem_rdata    fetched instruction
//   ins           registered instruction to decode (NOP when not valid)
//   pc_o          PC of ins
//   pc_plus4_o    pc_o + 4
//   ins_valid     ins/pc_o hold a real fetched instruction
module fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] pc_target,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] ins,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             ins_valid
);

  localparam logic [WIDTH-1:0] Four      = WIDTH'(4);
  localparam logic [WIDTH-1:0] AlignMask = ~WIDTH'(3);

  // StSkid means the skid buffer holds a fetched instruction; StRun means it is empty.
  typedef enum logic [0:0] {StRun, StSkid} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] ins_q, ins_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4_q;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] skid_ins_q, skid_ins_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  // The drop flag marks an outstanding request whose response must be thrown away
  // because a redirect arrived while it was in flight. drop_tgt holds where to
  // resume fetching afterwards.
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] drop_tgt_q, drop_tgt_d;

  logic             accept;
  logic [WIDTH-1:0] target;

  assign accept = req_q & imem_ready;
  assign target = pc_target & AlignMask;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    ins_d      = ins_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    skid_ins_d = skid_ins_q;
    skid_pc_d  = skid_pc_q;
    drop_d     = drop_q;
    drop_tgt_d = drop_tgt_q;

    if (pc_src) begin
      // A redirect outranks both stall and skid. Everything in flight is flushed.
      valid_d = 1'b0;
      ins_d   = NOP;
      state_d = StRun;
      req_d   = 1'b1;
      if (req_q && !imem_ready) begin
        // The request cannot be abandoned. Keep its address and remember the target.
        drop_d     = 1'b1;
        drop_tgt_d = target;
      end else begin
        // There is nothing outstanding, or the response is being accepted now and
        // is discarded here.
        fetch_pc_d = target;
        drop_d     = 1'b0;
      end
    end else if (state_q == StSkid) begin
      // While the skid is full, no request is in flight.
      if (!stall) begin
        ins_d   = skid_ins_q;
        pc_d    = skid_pc_q;
        valid_d = 1'b1;
        state_d = StRun;
        req_d   = 1'b1;
      end
    end else begin
      req_d = 1'b1;
      if (accept && drop_q) begin
        // This is the stale response from before a redirect. Discard it and resume
        // fetching at the redirect target.
        fetch_pc_d = drop_tgt_q;
        drop_d     = 1'b0;
        if (!stall) begin
          valid_d = 1'b0;
          ins_d   = NOP;
        end
      end else if (accept && stall) begin
        // Decode is frozen, so park the response and stop requesting until it drains.
        skid_ins_d = imem_rdata;
        skid_pc_d  = fetch_pc_q;
        state_d    = StSkid;
        req_d      = 1'b0;
        fetch_pc_d = fetch_pc_q + Four;
      end else if (accept) begin
        ins_d      = imem_rdata;
        pc_d       = fetch_pc_q;
        valid_d    = 1'b1;
        fetch_pc_d = fetch_pc_q + Four;
      end else if (!stall) begin
        valid_d = 1'b0;
        ins_d   = NOP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      ins_q      <= NOP;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + Four;
      valid_q    <= 1'b0;
      skid_ins_q <= NOP;
      skid_pc_q  <= RESET_PC;
      drop_q     <= 1'b0;
      drop_tgt_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      ins_q      <= ins_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_d + Four;
      valid_q    <= valid_d;
      skid_ins_q <= skid_ins_d;
      skid_pc_q  <= skid_pc_d;
      drop_q     <= drop_d;
      drop_tgt_q <= drop_tgt_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = fetch_pc_q;
  assign ins        = ins_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign ins_valid  = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit.
// The driver acts as instruction memory and generates the random stimulus. At every
// clock edge it applies the fetch rules to a transaction-level model: it tracks the
// next fetch address, pushes every instruction that should reach decode into a
// queue, and flushes the queue on a redirect. A separate monitor pops that queue
// each time decode consumes a valid instruction (ins_valid=1 and stall=0).
module tb_fetch_unit;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        ins_valid;

  fetch_unit #(.WIDTH(32), .RESET_PC(ResetPc), .NOP(Nop)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .pc_o       (pc_o),
    .pc_plus4_o (pc_plus4_o),
    .ins_valid  (ins_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc;     // address of the outstanding / next fetch
  logic [31:0] pend_tgt;   // redirect target waiting on a stale response
  bit          drop_m;
  bit          mon_en = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: it sees each edge at which decode takes an instruction.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && rst_n && ins_valid && !stall) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ins: got pc %h ins %h expected no valid output", pc_o, ins);
        end else begin
          e = sb.pop_front();
          check("pc_o", pc_o, e.pc);
          check("ins", ins, e.ins);
          check("pc_plus4_o", pc_plus4_o, e.pc + 32'd4);
        end
      end
    end
  end

  // Runs one clock cycle. Inputs are driven at the negedge. The model applies the
  // fetch rules to what happened at the following posedge.
  task automatic cycle(input bit rdy, input bit stl, input bit src, input logic [31:0] tgt);
    bit r;
    @(negedge clk);
    imem_ready = rdy;
    stall      = stl;
    pc_src     = src;
    pc_target  = tgt;
    imem_rdata = rdy ? mem(imem_addr) : $urandom();
    r = imem_req;
    if (r) check("imem_addr", imem_addr, exp_pc);
    @(posedge clk);
    #1;
    if (src) begin
      sb.delete();
      if (r && !rdy) begin
        drop_m   = 1'b1;
        pend_tgt = tgt & ~32'd3;
      end else begin
        exp_pc = tgt & ~32'd3;
        drop_m = 1'b0;
      end
    end else if (r && rdy) begin
      if (drop_m) begin
        exp_pc = pend_tgt;
        drop_m = 1'b0;
      end else begin
        sb.push_back('{pc: exp_pc, ins: mem(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_pc   = ResetPc;
    pend_tgt = ResetPc;
    drop_m   = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n      = 1'b0;
    pc_src     = 1'b0;
    pc_target  = '0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    model_reset();
    #12;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins", ins, Nop);
    check("rst_pc_o", pc_o, ResetPc);
    check("rst_pc_plus4", pc_plus4_o, ResetPc + 32'd4);
    check("rst_imem_addr", imem_addr, ResetPc);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Streaming case: memory is ready every cycle.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    // Memory waits 3 cycles before responding.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    // A 3-cycle stall while memory is ready.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    // Redirect while a request is outstanding, with a late response.
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    // Redirect during a stall with the skid full. The target has unaligned low bits.
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    // The fetch address wraps at the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
        1:       tgt = 32'($urandom_range(0, 255));
        default: tgt = $urandom();
      endcase
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
            $urandom_range(0, 11) == 0, tgt);
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drain("drain_after_random");

    // Reset asserted mid-request while memory is stalled.
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_imem_req", 32'(imem_req), 32'd0);
    check("async_rst_ins_valid", 32'(ins_valid), 32'd0);
    check("async_rst_imem_addr", imem_addr, ResetPc);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
